gray_codec_pipe: RTL and testbench
==================================

# gray_codec_pipe

Parametrised, pipelined Gray-code converter with a per-transaction mode select: each accepted word is either encoded (binary to Gray) or decoded (Gray to binary). It supersedes the purely combinational Gray decoder wherever wide words or high clock rates need the Gray-to-binary prefix-XOR chain split across register stages. It sits on valid/ready streams, for example between clock-domain-crossing pointer logic and FIFO occupancy arithmetic, and carries the mode bit through as sideband.

## Interface
- DATA_WIDTH, 8, word width in bits; legal range 2 or more.
- STAGES, 2, number of pipeline register stages; legal range 1 to DATA_WIDTH.
- Parameter checks: out-of-range values are rejected at elaboration with $error.
- i_clock  input  1  rising-edge clock; the block's only clock.
- i_aresetn  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  input word valid.
- o_ready  output  1  block can accept an input this cycle.
- i_mode  input  1  0 = encode (binary to Gray), 1 = decode (Gray to binary).
- i_data  input  DATA_WIDTH  input word.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the output this cycle.
- o_mode  output  1  mode of the word on o_data.
- o_data  output  DATA_WIDTH  converted word.

## Operation
- Encode: o_data = d ^ (d >> 1).
- Decode: o_data[DATA_WIDTH-1] = g[DATA_WIDTH-1]; o_data[i] = XOR of g[DATA_WIDTH-1:i].
- Decode is split into STAGES slices, ceil(DATA_WIDTH/STAGES) bits each, starting from the MSB.
  - Stage k resolves its slice using the running XOR carried forward from stage k-1.
  - Already-resolved bits and the unconverted remainder are both registered alongside.
  - No path between registers may contain more than ceil(DATA_WIDTH/STAGES)+1 XOR levels.
- Encode completes in stage 1, then is carried unchanged through the remaining stages.
  - This keeps latency identical for both modes, so mixed-mode streams stay in order.
- Each stage register holds: valid bit, mode bit, partial word, running-XOR bit.
- Global advance enable: adv = !o_valid || i_ready. All stages shift together when adv = 1 and hold when adv = 0.
- o_ready = adv. This is combinational from i_ready and o_valid; no combinational path from i_valid to o_ready.
- Input acceptance: a word is accepted when i_valid && o_ready at the rising edge.
  - When adv = 1 and i_valid = 0, a bubble (valid = 0) enters stage 1.
- Bubbles are not compressed. They occupy stage slots and drain only when adv = 1.
- o_valid, o_mode and o_data are driven directly from the last stage's registers.
- No state machine beyond the stage-valid shift register. Words exit strictly in acceptance order.

## Timing
- Reset (i_aresetn low): all stage valid, mode, data and running-XOR registers clear to 0 asynchronously.
  - Outputs during reset: o_valid = 0, o_mode = 0, o_data = 0.
  - o_ready = 1 during and after reset, because o_valid = 0.
- Release: the first acceptance can occur at the first rising edge after i_aresetn deasserts.
- Latency: a word accepted at edge k is presented on o_data/o_valid from edge k+STAGES-1 onward.
  - With STAGES = 1, it is registered once and visible in the next cycle.
- Throughput: one word per clock while i_ready = 1, regardless of mode mix.
- Backpressure: while o_valid && !i_ready:
  - o_data and o_mode are held stable;
  - all internal stages freeze;
  - o_ready = 0, so no input is accepted.
- Simultaneous handshake: if an output handshake and an input acceptance occur on the same edge, both complete; nothing is lost or duplicated.
- Reset mid-stream: every in-flight word is discarded. No partial output appears after release.
- All-zero and all-one words are legal.
  - Decode of all-ones alternates: for DATA_WIDTH = 8, 0xFF decodes to 0xAA.

## Test plan
- Default parameters, decode directed:
  - 0x80 gives 0xFF;
  - 0xC0 gives 0x80;
  - 0xFF gives 0xAA.
  - Each value appears exactly 2 cycles after acceptance with o_mode = 1.
- Encode directed: 0xFF gives 0x80, 0x80 gives 0xC0, 0x00 gives 0x00; o_mode = 0.
- Exhaustive round trip, DATA_WIDTH = 8:
  - stream all 256 values in encode mode, then feed the results back in decode mode;
  - the outputs must equal the originals, in order, at 1 word per cycle with i_ready tied high.
- Backpressure:
  - alternate encode and decode words, and drop i_ready for 3 cycles while o_valid = 1;
  - o_data must hold, o_ready must be 0 during the stall, and no word may be lost or reordered.
- Reset mid-operation:
  - assert i_aresetn low between clock edges while 2 words are in flight;
  - o_valid must go to 0 immediately and o_data must be 0;
  - after release, only newly accepted words may appear.
- Parameter corners:
  - STAGES = 1 and STAGES = DATA_WIDTH with DATA_WIDTH = 5;
  - random streams compared against a reference model;
  - latency must equal STAGES in both configurations.

Source files
------------

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter on valid/ready streams.
// Decode splits the prefix-XOR chain into MSB-first slices, one per stage.
module gray_codec_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 2
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_mode,
  output logic [DATA_WIDTH-1:0] o_data
);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("gray_codec_pipe: DATA_WIDTH must be >= 2");
  end
  if (STAGES < 1 || STAGES > DATA_WIDTH) begin : g_bad_stages
    $error("gray_codec_pipe: STAGES must be 1..DATA_WIDTH");
  end

  localparam int SLICE = (DATA_WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0]     vld_q, vld_d;
  logic [STAGES-1:0]     mode_q, mode_d;
  logic [STAGES-1:0]     x_q, x_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];

  logic [STAGES-1:0]     src_v;
  logic [STAGES-1:0]     src_m;
  logic [STAGES-1:0]     src_x;
  logic [DATA_WIDTH-1:0] src_d [STAGES];

  logic adv;
  logic x_unused;

  assign adv      = !vld_q[STAGES-1] || i_ready;
  assign o_ready  = adv;
  assign o_valid  = vld_q[STAGES-1];
  assign o_mode   = mode_q[STAGES-1];
  assign o_data   = data_q[STAGES-1];
  // The last stage has nothing left to carry its running XOR into.
  assign x_unused = x_q[STAGES-1];

  always_comb begin
    src_v[0] = i_valid;
    src_m[0] = i_mode;
    src_x[0] = 1'b0;
    src_d[0] = i_data;
    for (int s = 1; s < STAGES; s++) begin
      src_v[s] = vld_q[s-1];
      src_m[s] = mode_q[s-1];
      src_x[s] = x_q[s-1];
      src_d[s] = data_q[s-1];
    end
  end

  always_comb begin
    logic x;
    int   hi;
    int   lo;
    x  = 1'b0;
    hi = 0;
    lo = 0;
    for (int s = 0; s < STAGES; s++) begin
      vld_d[s]  = src_v[s];
      mode_d[s] = src_m[s];
      data_d[s] = src_d[s];
      x         = src_x[s];
      hi        = DATA_WIDTH - 1 - s * SLICE;
      lo        = hi - SLICE + 1;
      if (src_m[s]) begin
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
          if (i <= hi && i >= lo) begin
            x            = x ^ src_d[s][i];
            data_d[s][i] = x;
          end
        end
      end else if (s == 0) begin
        data_d[s] = src_d[s] ^ (src_d[s] >> 1);
      end
      x_d[s] = x;
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      vld_q  <= '0;
      mode_q <= '0;
      x_q    <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      x_q    <= x_d;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: default config plus
// DATA_WIDTH=5 corners at STAGES=1 and STAGES=5.
module tb_gray_codec_pipe;

  logic       clk;
  logic       rst_n;
  logic       valid, ready_in, mode;
  logic [7:0] din;
  logic       o_ready, o_valid, o_mode;
  logic [7:0] o_data;

  logic       c_valid, c_mode;
  logic [4:0] c_din;
  logic       a_ready, a_valid, a_mode;
  logic [4:0] a_data;
  logic       b_ready, b_valid, b_mode;
  logic [4:0] b_data;

  int n_cmp;
  int n_err;

  logic [7:0] enc_res [256];
  logic       hv [64];
  logic       hm [64];
  logic [4:0] hd [64];

  gray_codec_pipe #(.DATA_WIDTH(8), .STAGES(2)) dut (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_valid(valid), .o_ready(o_ready), .i_mode(mode),
    .i_data(din), .o_valid(o_valid), .i_ready(ready_in),
    .o_mode(o_mode), .o_data(o_data)
  );

  gray_codec_pipe #(.DATA_WIDTH(5), .STAGES(1)) dut_a (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_valid(c_valid), .o_ready(a_ready), .i_mode(c_mode),
    .i_data(c_din), .o_valid(a_valid), .i_ready(1'b1),
    .o_mode(a_mode), .o_data(a_data)
  );

  gray_codec_pipe #(.DATA_WIDTH(5), .STAGES(5)) dut_b (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_valid(c_valid), .o_ready(b_ready), .i_mode(c_mode),
    .i_data(c_din), .o_valid(b_valid), .i_ready(1'b1),
    .o_mode(b_mode), .o_data(b_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gdec(input logic [7:0] g, input int w);
    logic [7:0] r;
    logic       x;
    r = '0;
    x = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      x    = x ^ g[i];
      r[i] = x;
    end
    return r;
  endfunction

  function automatic logic [7:0] genc(input logic [7:0] d);
    return d ^ (d >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic m, input logic [7:0] d,
                       input logic [7:0] exp, input string tag);
    valid = 1'b1;
    mode  = m;
    din   = d;
    step();
    chk({tag, "_early"}, {31'd0, o_valid}, 32'd0);
    valid = 1'b0;
    step();
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_mode"}, {31'd0, o_mode}, {31'd0, m});
    chk({tag, "_data"}, {24'd0, o_data}, {24'd0, exp});
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    ready_in = 1'b1;
    mode     = 1'b0;
    din      = '0;
    c_valid  = 1'b0;
    c_mode   = 1'b0;
    c_din    = '0;

    // Reset state
    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_mode", {31'd0, o_mode}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed decode / encode
    send1(1'b1, 8'h80, 8'hFF, "dec80");
    send1(1'b1, 8'hC0, 8'h80, "decC0");
    send1(1'b1, 8'hFF, 8'hAA, "decFF");
    send1(1'b0, 8'hFF, 8'h80, "encFF");
    send1(1'b0, 8'h80, 8'hC0, "enc80");
    send1(1'b0, 8'h00, 8'h00, "enc00");
    step();

    // Exhaustive round trip, one word per cycle
    for (int c = 0; c <= 256; c++) begin
      valid = (c < 256);
      mode  = 1'b0;
      din   = 8'(c);
      step();
      if (c >= 1) begin
        chk("enc_stream_v", {31'd0, o_valid}, 32'd1);
        chk("enc_stream_d", {24'd0, o_data}, {24'd0, genc(8'(c - 1))});
        enc_res[c-1] = o_data;
      end
    end
    for (int c = 0; c <= 256; c++) begin
      valid = (c < 256);
      mode  = 1'b1;
      din   = (c < 256) ? enc_res[c] : 8'h00;
      step();
      if (c >= 1) begin
        chk("dec_stream_v", {31'd0, o_valid}, 32'd1);
        chk("dec_stream_m", {31'd0, o_mode}, 32'd1);
        chk("dec_stream_d", {24'd0, o_data}, 32'(c - 1));
      end
    end
    valid = 1'b0;
    step();
    chk("drain", {31'd0, o_valid}, 32'd0);

    // Backpressure with mixed modes
    valid = 1'b1; mode = 1'b0; din = 8'h35;
    step();
    valid = 1'b1; mode = 1'b1; din = 8'h5A;
    step();
    chk("bp_w0", {24'd0, o_data}, 32'h2F);
    chk("bp_w0_m", {31'd0, o_mode}, 32'd0);
    valid = 1'b1; mode = 1'b0; din = 8'h0F;
    ready_in = 1'b0;
    #1;
    chk("bp_ready0", {31'd0, o_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_v", {31'd0, o_valid}, 32'd1);
      chk("bp_hold_d", {24'd0, o_data}, 32'h2F);
      chk("bp_hold_r", {31'd0, o_ready}, 32'd0);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_ready1", {31'd0, o_ready}, 32'd1);
    step();
    chk("bp_w1", {24'd0, o_data}, 32'h6C);
    chk("bp_w1_m", {31'd0, o_mode}, 32'd1);
    valid = 1'b1; mode = 1'b1; din = 8'hF0;
    step();
    chk("bp_w2", {24'd0, o_data}, 32'h08);
    chk("bp_w2_m", {31'd0, o_mode}, 32'd0);
    valid = 1'b0;
    step();
    chk("bp_w3", {24'd0, o_data}, 32'hA0);
    chk("bp_w3_m", {31'd0, o_mode}, 32'd1);
    step();
    chk("bp_empty", {31'd0, o_valid}, 32'd0);

    // Reset with two words in flight
    valid = 1'b1; mode = 1'b0; din = 8'h12;
    step();
    valid = 1'b1; mode = 1'b1; din = 8'h34;
    step();
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, o_valid}, 32'd0);
    chk("mrst_data", {24'd0, o_data}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst_quiet", {31'd0, o_valid}, 32'd0);
    end
    send1(1'b0, 8'h55, 8'h7F, "mrst_new");
    step();

    // DATA_WIDTH=5 corners, random stream
    for (int c = 0; c < 48; c++) begin
      hv[c] = 1'($urandom_range(0, 3) != 0);
      hm[c] = 1'($urandom_range(0, 1));
      hd[c] = 5'($urandom_range(0, 31));
      c_valid = hv[c];
      c_mode  = hm[c];
      c_din   = hd[c];
      step();
      chk("s1_valid", {31'd0, a_valid}, {31'd0, hv[c]});
      if (hv[c]) begin
        chk("s1_mode", {31'd0, a_mode}, {31'd0, hm[c]});
        chk("s1_data", {27'd0, a_data},
            {24'd0, hm[c] ? gdec({3'd0, hd[c]}, 5) : genc({3'd0, hd[c]})});
      end
      if (c >= 4) begin
        chk("s5_valid", {31'd0, b_valid}, {31'd0, hv[c-4]});
        if (hv[c-4]) begin
          chk("s5_mode", {31'd0, b_mode}, {31'd0, hm[c-4]});
          chk("s5_data", {27'd0, b_data},
              {24'd0, hm[c-4] ? gdec({3'd0, hd[c-4]}, 5)
                              : genc({3'd0, hd[c-4]})});
        end
      end else begin
        chk("s5_fill", {31'd0, b_valid}, 32'd0);
      end
    end
    c_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
